// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types, constants and helpers for the push-button
//                debouncer (key state encoding, counter sizing, logic levels).
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    // Per-key debounce/repeat state
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } key_state_t;

    // Logic-level names: n* for active-low pins, p* for positive-logic nets
    localparam logic nT = 1'b0;
    localparam logic nF = 1'b1;
    localparam logic pT = 1'b1;
    localparam logic pF = 1'b0;

    // Width needed to hold the largest terminal count without wrapping
    function automatic int cnt_width(input int deb, input int rep_dly, input int rep_per);
        int m;
        m = deb;
        if (rep_dly > m) m = rep_dly;
        if (rep_per > m) m = rep_per;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_if
//  Description : Bundle of raw key pins and conditioned key events.
//                master = the side driving the pins and consuming events,
//                slave  = the debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if #(
    parameter int NKEY = 3
);
    logic [NKEY-1:0] n_key;
    logic [NKEY-1:0] key_level;
    logic [NKEY-1:0] key_press;
    logic [NKEY-1:0] key_release;
    logic [NKEY-1:0] key_repeat;

    modport master (
        output n_key,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_repeat
    );

    modport slave (
        input  n_key,
        output key_level,
        output key_press,
        output key_release,
        output key_repeat
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_ch
//  Description : One key: two-flop synchroniser, debounce/repeat FSM with a
//                shared stability counter, registered level and strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB     = 500_000,
    parameter int REP_DLY = 25_000_000,
    parameter int REP_PER = 5_000_000
) (
    input  wire  clk,
    input  wire  n_rst,
    input  wire  n_key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int              CW         = cnt_width(DEB, REP_DLY, REP_PER);
    localparam logic [CW-1:0]   c_DEB_LAST = CW'(DEB - 1);
    localparam logic [CW-1:0]   c_DLY_LAST = (REP_DLY == 0) ? '0 : CW'(REP_DLY - 1);
    localparam logic [CW-1:0]   c_PER_LAST = CW'(REP_PER - 1);
    localparam logic [CW-1:0]   c_CNT_MAX  = '1;
    localparam bit              c_REP_EN   = (REP_DLY != 0);

    logic            r_sync1;
    logic            r_sync2;
    logic            w_raw;
    key_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_repeat;

    // Bring the asynchronous active-low pin into the clock domain as positive logic
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= pF;
            r_sync2 <= pF;
        end else begin
            r_sync1 <= (n_key == nT) ? pT : pF;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = r_sync2;

    // Debounce / auto-repeat state machine; strobes default low every cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= pF;
            r_press   <= pF;
            r_release <= pF;
            r_repeat  <= pF;
        end else begin
            r_press   <= pF;
            r_release <= pF;
            r_repeat  <= pF;
            case (r_state)
                IDLE: begin
                    if (w_raw) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_raw) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_level <= pT;
                        r_press <= pT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_raw) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end else if (c_REP_EN && (r_cnt == c_DLY_LAST)) begin
                        r_state  <= REPEAT;
                        r_cnt    <= '0;
                        r_repeat <= pT;
                    end else if (r_cnt != c_CNT_MAX) begin
                        // Saturates when repeat is disabled and the key is held forever
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!w_raw) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_PER_LAST) begin
                        r_cnt    <= '0;
                        r_repeat <= pT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_raw) begin
                        // Release bounce: back to HELD, repeat delay restarts
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_level   <= pF;
                        r_release <= pT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : NKEY independent push-button conditioners producing debounced
//                level, press/release strobes and auto-repeat strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int NKEY    = 3,
    parameter int DEB     = 500_000,
    parameter int REP_DLY = 25_000_000,
    parameter int REP_PER = 5_000_000
) (
    input  wire             clk,
    input  wire             n_rst,
    key_debounce_if.slave   kif
);

    logic [NKEY-1:0] w_level;
    logic [NKEY-1:0] w_press;
    logic [NKEY-1:0] w_release;
    logic [NKEY-1:0] w_repeat;

    // One fully independent channel per key, no arbitration between them
    for (genvar g = 0; g < NKEY; g++) begin : g_key
        key_debounce_ch #(
            .DEB     (DEB),
            .REP_DLY (REP_DLY),
            .REP_PER (REP_PER)
        ) u_ch (
            .clk         (clk),
            .n_rst       (n_rst),
            .n_key       (kif.n_key[g]),
            .key_level   (w_level[g]),
            .key_press   (w_press[g]),
            .key_release (w_release[g]),
            .key_repeat  (w_repeat[g])
        );
    end

    assign kif.key_level   = w_level;
    assign kif.key_press   = w_press;
    assign kif.key_release = w_release;
    assign kif.key_repeat  = w_repeat;

endmodule
`default_nettype wire
